// File: rtl/regfile_nrport.sv
// regfile_nrport: one-write, NUM_RD-read register file with per-port forwarding and stall hold
module regfile_nrport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         wen,
    input  logic                         stall
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    logic we_eff;
    assign we_eff = wen && rst && !((ZERO_REG != 0) && wr_addr == '0);
    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [ADDR_WIDTH-1:0] ra_in, ra_d, ra_q;
        logic [DATA_WIDTH-1:0] dq_d, dq_q;
        assign ra_in = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        always_ff @(posedge clk)
            if (we_eff) mem[wr_addr] <= wr_data;
        // while stalled only a write to the held index may refresh the operand
        always_comb begin
            ra_d = stall ? ra_q : ra_in;
            dq_d = stall ? ((we_eff && wr_addr == ra_q) ? wr_data : dq_q)
                 : ((ZERO_REG != 0) && ra_in == '0) ? '0
                 : (we_eff && wr_addr == ra_in) ? wr_data
                 : mem[ra_in];
        end
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                ra_q <= '0;
                dq_q <= '0;
            end else begin
                ra_q <= ra_d;
                dq_q <= dq_d;
            end
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = dq_q;
    end
endmodule

// File: tb/tb_regfile_nrport.sv
// tb_regfile_nrport: scoreboard bench over default, ZERO_REG=0 and narrow NUM_RD=1/3/4 instances
module tb_regfile_nrport;
    logic        clk, rst, wen, stall;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [9:0]  ra0;
    logic [63:0] rd0;
    logic [4:0]  ra1;
    logic [31:0] rd1;
    logic        wen_s;
    logic [2:0]  wa_s;
    logic [7:0]  wd_s;
    logic [2:0]  ra2;
    logic [7:0]  rd2;
    logic [8:0]  ra3;
    logic [23:0] rd3;
    logic [11:0] ra4;
    logic [31:0] rd4;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        int          d;
        int          p;
        logic [31:0] e;
    } exp_t;
    exp_t sb[$];

    regfile_nrport u0 (.clk(clk), .rst(rst), .rd_addr(ra0), .rd_data(rd0), .wr_addr(wr_addr),
                       .wr_data(wr_data), .wen(wen), .stall(stall));
    regfile_nrport #(.NUM_RD(1), .ZERO_REG(0)) u1 (.clk(clk), .rst(rst), .rd_addr(ra1), .rd_data(rd1),
                       .wr_addr(wr_addr), .wr_data(wr_data), .wen(wen), .stall(stall));
    regfile_nrport #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_RD(1)) u2 (.clk(clk), .rst(rst), .rd_addr(ra2),
                       .rd_data(rd2), .wr_addr(wa_s), .wr_data(wd_s), .wen(wen_s), .stall(stall));
    regfile_nrport #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_RD(3)) u3 (.clk(clk), .rst(rst), .rd_addr(ra3),
                       .rd_data(rd3), .wr_addr(wa_s), .wr_data(wd_s), .wen(wen_s), .stall(stall));
    regfile_nrport #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_RD(4)) u4 (.clk(clk), .rst(rst), .rd_addr(ra4),
                       .rd_data(rd4), .wr_addr(wa_s), .wr_data(wd_s), .wen(wen_s), .stall(stall));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_of(input int d, input int p);
        case (d)
            0:       return rd0[p*32 +: 32];
            1:       return rd1;
            2:       return {24'b0, rd2};
            3:       return {24'b0, rd3[p*8 +: 8]};
            default: return {24'b0, rd4[p*8 +: 8]};
        endcase
    endfunction

    function automatic logic [7:0] sval(input int i);
        return (i == 0) ? 8'h00 : 8'(32'hA0 ^ (i * 19));
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic expect_rd(input string tag, input int d, input int p, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.d = d;
        x.p = p;
        x.e = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        while (sb.size() != 0) begin
            x = sb.pop_front();
            check(x.tag, rd_of(x.d, x.p), x.e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        wen = 1'b1;
        wr_addr = a;
        wr_data = v;
        tick();
        wen = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wen = 1'b0; stall = 1'b0; wr_addr = '0; wr_data = '0;
        ra0 = '0; ra1 = '0; wen_s = 1'b0; wa_s = '0; wd_s = '0; ra2 = '0; ra3 = '0; ra4 = '0;
        tick();
        expect_rd("rst_p0", 0, 0, 0);
        expect_rd("rst_p1", 0, 1, 0);
        expect_rd("rst_u1", 1, 0, 0);
        expect_rd("rst_u4p3", 4, 3, 0);
        tick();
        rst = 1'b1;
        wen = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        expect_rd("basic_r0", 0, 0, 0);
        tick();
        wen = 1'b0; ra0 = {5'd0, 5'd3};
        expect_rd("basic_r3", 0, 0, 32'hDEADBEEF);
        tick();
        wr(5'd5, 32'h11);
        wen = 1'b1; wr_addr = 5'd5; wr_data = 32'h22; ra0 = {5'd5, 5'd5};
        expect_rd("fwd_p0", 0, 0, 32'h22);
        expect_rd("fwd_p1", 0, 1, 32'h22);
        tick();
        wen = 1'b0;
        expect_rd("fwd_after_p0", 0, 0, 32'h22);
        expect_rd("fwd_after_p1", 0, 1, 32'h22);
        tick();
        wr(5'd7, 32'hA);
        wr(5'd8, 32'hB);
        wr(5'd1, 32'h111);
        ra0 = {5'd8, 5'd7};
        expect_rd("stl_set_p0", 0, 0, 32'hA);
        expect_rd("stl_set_p1", 0, 1, 32'hB);
        tick();
        stall = 1'b1; ra0 = {5'd1, 5'd1};
        expect_rd("stl1_p0", 0, 0, 32'hA);
        expect_rd("stl1_p1", 0, 1, 32'hB);
        tick();
        wen = 1'b1; wr_addr = 5'd8; wr_data = 32'hC;
        expect_rd("stl2_p0", 0, 0, 32'hA);
        expect_rd("stl2_p1", 0, 1, 32'hC);
        tick();
        wen = 1'b0;
        expect_rd("stl3_p0", 0, 0, 32'hA);
        expect_rd("stl3_p1", 0, 1, 32'hC);
        tick();
        stall = 1'b0;
        expect_rd("unstl_p0", 0, 0, 32'h111);
        expect_rd("unstl_p1", 0, 1, 32'h111);
        tick();
        wen = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF; ra0 = '0; ra1 = '0;
        expect_rd("zr_wr", 0, 0, 0);
        expect_rd("nzr_fwd", 1, 0, 32'hFFFF);
        tick();
        wen = 1'b0;
        expect_rd("zr_rd", 0, 0, 0);
        expect_rd("nzr_rd", 1, 0, 32'hFFFF);
        tick();
        wr(5'd9, 32'h1234);
        ra0 = {5'd0, 5'd9};
        expect_rd("pre_rst", 0, 0, 32'h1234);
        tick();
        rst = 1'b0;
        #1;
        expect_rd("async_rst", 0, 0, 0);
        drain();
        wen = 1'b1; wr_addr = 5'd9; wr_data = 32'hBAD;
        expect_rd("in_rst", 0, 0, 0);
        tick();
        rst = 1'b1; wen = 1'b0;
        expect_rd("post_rst", 0, 0, 32'h1234);
        tick();
        wen_s = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wa_s = 3'(i);
            wd_s = 8'(32'hA0 ^ (i * 19));
            tick();
        end
        wen_s = 1'b0;
        for (int j = 0; j < 8; j++) begin
            ra2 = 3'(j);
            expect_rd("sw_n1", 2, 0, {24'b0, sval(j)});
            for (int p = 0; p < 3; p++) begin
                ra3[p*3 +: 3] = 3'((j + p) % 8);
                expect_rd("sw_n3", 3, p, {24'b0, sval((j + p) % 8)});
            end
            for (int p = 0; p < 4; p++) begin
                ra4[p*3 +: 3] = 3'((j + p) % 8);
                expect_rd("sw_n4", 4, p, {24'b0, sval((j + p) % 8)});
            end
            tick();
        end
        wen_s = 1'b1; wa_s = 3'd7; wd_s = 8'hEE;
        tick();
        wen_s = 1'b0;
        ra4 = {3'd7, 3'd6, 3'd0, 3'd7};
        expect_rd("wrap_p0", 4, 0, 32'hEE);
        expect_rd("wrap_p1", 4, 1, 0);
        expect_rd("wrap_p2", 4, 2, {24'b0, sval(6)});
        expect_rd("wrap_p3", 4, 3, 32'hEE);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_nrport.md
Name: regfile_nrport

Overview:
- Parametrised register file with one write port and NUM_RD synchronous read ports.
- Built from NUM_RD replicated pseudo-dual-port RAM banks that share the write port. Each bank has a registered read-data stage.
- Same-cycle write-to-read forwarding and stall hold are handled per port, so pipeline operands stay correct across stalls.
- Successor to the fixed 2-read-port CPU register file; used in the decode/operand-fetch stage.

Parameters:
- DATA_WIDTH, 32, width of each register in bits.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH.
- NUM_RD, 2, number of read ports; legal range 1..4.
- ZERO_REG, 1, when 1 index 0 is hardwired: it reads 0 and writes to it are discarded.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rd_addr  input  NUM_RD*ADDR_WIDTH  read indices; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  output  NUM_RD*DATA_WIDTH  read data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_addr  input  ADDR_WIDTH  write index.
- wr_data  input  DATA_WIDTH  write data.
- wen  input  1  write enable.
- stall  input  1  pipeline stall; freezes read ports.

Behaviour:
- Effective write: we_eff = wen && rst && !(ZERO_REG && wr_addr==0).
  - At the clock edge, mem[wr_addr] <= wr_data when we_eff.
  - All NUM_RD banks are written identically.
- Per port i there are two state registers:
  - ra_i: held read index, ADDR_WIDTH bits.
  - dq_i: output data, DATA_WIDTH bits. rd_data port i = dq_i directly; no combinational path from inputs.
- Reset (rst low, asynchronous):
  - ra_i and dq_i go to 0, so every rd_data reads 0.
  - RAM contents are not cleared; writes while rst is low are ignored.
  - Release of reset is synchronised externally. First valid read data appears one edge after release.
- Non-stalled cycle (stall=0), at the edge:
  - ra_i <= rd_addr_i.
  - dq_i <= 0 if ZERO_REG && rd_addr_i==0.
  - Otherwise dq_i <= wr_data if we_eff && wr_addr==rd_addr_i (forwarding).
  - Otherwise dq_i <= mem[rd_addr_i] (pre-write contents).
  - Read latency is exactly 1 cycle.
- Stalled cycle (stall=1), at the edge:
  - ra_i holds; rd_addr_i is ignored.
  - dq_i <= wr_data if we_eff && wr_addr==ra_i. Otherwise dq_i holds.
  - A write landing on a held operand during a stall is therefore visible on the next cycle and survives the stall.
- Stall release: on the first cycle with stall=0, rd_addr is sampled normally.
- Multiple ports reading the same index all forward identically and independently.
- Write and read of index 0 with ZERO_REG=1: no forwarding; the read returns 0.
- ZERO_REG=0: index 0 is an ordinary register.
- Read of a never-written register returns RAM power-up content, X in simulation. Benches must initialise registers before checking them.
- All address comparisons are full ADDR_WIDTH equality; there is no wrap or aliasing.

Test Plan:
- Basic write/read: reset, write r3=0xDEADBEEF, then a later cycle rd_addr0=3 -> rd_data0=0xDEADBEEF one cycle after the address is presented.
- Forwarding: r5=0x11; same cycle wen, wr_addr=5, wr_data=0x22, rd_addr0=rd_addr1=5 -> both ports read 0x22 next cycle, and r5 reads 0x22 thereafter.
- Stall hold with write:
  - Setup: r7=0xA, r8=0xB; rd_addr0=7, rd_addr1=8, then stall=1 for 3 cycles.
  - During the stall: rd_addr changed to 1; write r8=0xC in stall cycle 2.
  - Required: port0 holds 0xA throughout; port1 shows 0xB, then 0xC from the cycle after the write.
  - After stall=0, ports follow the new rd_addr.
- Zero register (ZERO_REG=1): write r0=0xFFFF with rd_addr0=0 -> rd_data0=0 on every cycle.
- ZERO_REG=0 variant: the same write reads back 0xFFFF.
- Reset mid-operation: with rd_data0=0x1234 from r9, drive rst low between edges -> rd_data0=0 immediately (asynchronous). Release rst with rd_addr0=9 -> 0x1234 after one edge (contents retained).
- Parameter sweep: NUM_RD=1,3,4; DATA_WIDTH=8; ADDR_WIDTH=3. Write every index with its own value, read all through every port -> exact match; write to index 7 reads back with no wrap.
